tl_ul_scratch_responder: RTL

TileLink-UL responder (manager) terminating one A/D channel pair. It serves Get, PutFullData and PutPartialData from a local scratchpad and buffers responses in a small queue. It is the D-channel source for the same A/D port our TL monitors check, and it gives monitor benches a protocol-correct far end. Unsupported or illegal requests get a denied response instead of being dropped.

---
 rtl/tl_ul_scratch_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_scratch_responder.sv
// TileLink-UL responder terminating one A/D channel pair.
// Serves Get / PutFullData / PutPartialData from a local scratchpad and
// returns responses in acceptance order through a DEPTH-entry queue.
// Illegal or unsupported requests receive a denied response.
// Optional build macro: TL_RESP_STALL_EN. It adds LFSR-driven jitter on
// when the next queued response is started.
module tl_ul_scratch_responder #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [3:0]          a_size,
    input  logic [6:0]          a_source,
    input  logic [13:0]         a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [3:0]          d_size,
    output logic [6:0]          d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [DATA_W-1:0]   d_data,
    output logic                d_corrupt
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(MASK_W);
    localparam int unsigned IDX_W  = 14 - OFF_W;
    localparam int unsigned MW_W   = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_ARITHMETIC  = 3'd2,
        A_LOGICAL     = 3'd3,
        A_GET         = 3'd4,
        A_INTENT      = 3'd5
    } a_op_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2
    } d_op_e;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [3:0]        size;
        logic [6:0]        source;
        logic              denied;
        logic              corrupt;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    resp_t             q_mem [DEPTH];

    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              d_valid_q, d_valid_d;

    logic              push, pop, stall, legal, mem_we;
    logic [IDX_W-1:0]  idx;
    logic [13:0]       align_mask;
    resp_t             new_resp, head;

    // a_param carries no meaning for the operations served here
    logic unused_a_param;
    assign unused_a_param = ^a_param;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef TL_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; bit 0 gates starting the next response
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // LFSR state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    assign a_ready = (count_q != CNT_W'(DEPTH));
    assign push    = a_valid & a_ready;
    assign pop     = d_valid_q & d_ready;

    // Request decode: legality check and the response payload to enqueue
    always_comb begin
        idx        = a_address[13:OFF_W];
        align_mask = ~(14'h3FFF << a_size);
        legal      = (32'(idx) < MEM_WORDS) && (32'(a_size) <= OFF_W) &&
                     ((a_address & align_mask) == '0);
        mem_we     = 1'b0;
        new_resp   = '{opcode: D_ACCESS_ACK, size: a_size, source: a_source,
                       denied: 1'b0, corrupt: 1'b0, data: '0};
        case (a_op_e'(a_opcode))
            A_GET: begin
                new_resp.opcode = D_ACCESS_ACK_DATA;
                if (legal) begin
                    new_resp.data = mem_q[idx[MW_W-1:0]];
                end else begin
                    new_resp.denied  = 1'b1;
                    new_resp.corrupt = 1'b1;
                end
            end
            A_PUT_FULL, A_PUT_PARTIAL: begin
                new_resp.denied = ~legal;
                mem_we          = push & legal & ~a_corrupt;
            end
            A_ARITHMETIC, A_LOGICAL: begin
                new_resp.opcode  = D_ACCESS_ACK_DATA;
                new_resp.denied  = 1'b1;
                new_resp.corrupt = 1'b1;
            end
            A_INTENT: begin
                new_resp.opcode = D_HINT_ACK;
            end
            default: begin
                new_resp.denied = 1'b1;
            end
        endcase
    end

    // Scratchpad byte-lane writes; contents deliberately not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < MASK_W; b++) begin
                if (a_mask[b]) mem_q[idx[MW_W-1:0]][8*b +: 8] <= a_data[8*b +: 8];
            end
        end
    end

    // Response queue storage
    always_ff @(posedge clock) begin
        if (push) q_mem[wptr_q] <= new_resp;
    end

    // Queue pointers, occupancy and D-valid next state.
    // d_valid is held while unacknowledged; a new head is only started when not stalled.
    always_comb begin
        wptr_d    = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d    = pop ? ptr_inc(rptr_q) : rptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        d_valid_d = (d_valid_q & ~d_ready) | ((count_d != '0) & ~stall);
    end

    // Queue control registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            d_valid_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            d_valid_q <= d_valid_d;
        end
    end

    // D channel driven from the queue head, zeroed while no beat is presented
    always_comb begin
        head      = q_mem[rptr_q];
        d_valid   = d_valid_q;
        d_param   = '0;
        d_sink    = 1'b0;
        d_opcode  = d_valid_q ? head.opcode  : '0;
        d_size    = d_valid_q ? head.size    : '0;
        d_source  = d_valid_q ? head.source  : '0;
        d_denied  = d_valid_q ? head.denied  : 1'b0;
        d_corrupt = d_valid_q ? head.corrupt : 1'b0;
        d_data    = d_valid_q ? head.data    : '0;
    end

endmodule
